// File: rtl/eject_sink.sv
// Ejection endpoint on a router's local output port: frames packets per VC,
// checks destinations, returns delayed credits and signals completion.
module eject_sink #(
    parameter int NODE_ID      = 0,
    parameter int NUM_VC       = 4,
    parameter int VC_BITS      = 2,
    parameter int DST_BITS     = 14,
    parameter int CNT_BITS     = 10,
    parameter int CREDIT_DELAY = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [3:0]          op,
    input  logic [CNT_BITS-1:0] init_count,
    input  logic                flit_full,
    input  logic [VC_BITS-1:0]  flit_vc,
    input  logic                flit_head,
    input  logic                flit_tail,
    input  logic [DST_BITS-1:0] flit_dst,
    output logic                cr_valid,
    output logic [VC_BITS-1:0]  cr_vc,
    output logic [CNT_BITS-1:0] pkt_count,
    output logic [CNT_BITS-1:0] flit_count,
    output logic                done,
    output logic                err,
    output logic [1:0]          err_code
);

    localparam logic [3:0] OP_INIT = 4'd5;
    localparam logic [1:0] EC_FRAME = 2'd1;
    localparam logic [1:0] EC_DST   = 2'd2;
    localparam logic [1:0] EC_OVF   = 2'd3;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } vc_state_t;

    vc_state_t           r_vc_state   [NUM_VC];
    vc_state_t           w_vc_state_n [NUM_VC];
    vc_state_t           w_cur;
    logic [CNT_BITS-1:0] r_pkt_count;
    logic [CNT_BITS-1:0] r_flit_count;
    logic [CNT_BITS-1:0] r_expected;
    logic [CNT_BITS-1:0] w_pkt_n;
    logic                r_armed;
    logic                r_done;
    logic                r_err;
    logic [1:0]          r_err_code;
    logic                r_cr_v  [CREDIT_DELAY];
    logic [VC_BITS-1:0]  r_cr_vc [CREDIT_DELAY];

    logic w_init;
    logic w_acc;
    logic w_pkt_inc;
    logic w_frame_err;
    logic w_dst_err;
    logic w_ovf_err;
    logic w_any_busy_n;
    logic w_done_n;

    assign w_init = (op == OP_INIT);
    assign w_acc  = flit_full & ~w_init;

    always_comb begin
        w_vc_state_n = r_vc_state;
        w_pkt_inc    = 1'b0;
        w_frame_err  = 1'b0;
        w_cur        = r_vc_state[flit_vc];
        if (w_acc) begin
            unique case (w_cur)
                ST_IDLE: begin
                    if (flit_head) begin
                        if (flit_tail) w_pkt_inc = 1'b1;
                        else w_vc_state_n[flit_vc] = ST_BUSY;
                    end else begin
                        w_frame_err = 1'b1;
                    end
                end
                ST_BUSY: begin
                    // A head here abandons the open packet and starts anew.
                    if (flit_head) begin
                        w_frame_err = 1'b1;
                        if (flit_tail) begin
                            w_pkt_inc = 1'b1;
                            w_vc_state_n[flit_vc] = ST_IDLE;
                        end
                    end else if (flit_tail) begin
                        w_pkt_inc = 1'b1;
                        w_vc_state_n[flit_vc] = ST_IDLE;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        w_any_busy_n = 1'b0;
        for (int i = 0; i < NUM_VC; i++) begin
            if (w_vc_state_n[i] == ST_BUSY) w_any_busy_n = 1'b1;
        end
    end

    assign w_dst_err = w_acc && (flit_dst != DST_BITS'(NODE_ID));
    assign w_ovf_err = w_pkt_inc && r_armed &&
                       (r_pkt_count == r_expected) && (r_pkt_count != '1);

    always_comb begin
        w_pkt_n = r_pkt_count;
        if (w_init) w_pkt_n = '0;
        else if (w_pkt_inc && (r_pkt_count != '1)) w_pkt_n = r_pkt_count + 1'b1;
    end

    assign w_done_n = w_init ? (init_count == '0)
                             : (r_armed && (w_pkt_n == r_expected) && !w_any_busy_n);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_VC; i++) r_vc_state[i] <= ST_IDLE;
            r_pkt_count  <= '0;
            r_flit_count <= '0;
            r_expected   <= '0;
            r_armed      <= 1'b0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
            r_err_code   <= 2'd0;
        end else begin
            r_pkt_count <= w_pkt_n;
            r_done      <= w_done_n;
            if (w_init) begin
                for (int i = 0; i < NUM_VC; i++) r_vc_state[i] <= ST_IDLE;
                r_flit_count <= '0;
                r_expected   <= init_count;
                r_armed      <= 1'b1;
                r_err        <= 1'b0;
                r_err_code   <= 2'd0;
            end else begin
                r_vc_state <= w_vc_state_n;
                if (w_acc && (r_flit_count != '1)) r_flit_count <= r_flit_count + 1'b1;
                if (!r_err) begin
                    if (w_frame_err) begin
                        r_err      <= 1'b1;
                        r_err_code <= EC_FRAME;
                    end else if (w_dst_err) begin
                        r_err      <= 1'b1;
                        r_err_code <= EC_DST;
                    end else if (w_ovf_err) begin
                        r_err      <= 1'b1;
                        r_err_code <= EC_OVF;
                    end
                end
            end
        end
    end

    // Credit return: one stage per cycle of delay, tail stage drives the port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < CREDIT_DELAY; i++) begin
                r_cr_v[i]  <= 1'b0;
                r_cr_vc[i] <= '0;
            end
        end else if (w_init) begin
            for (int i = 0; i < CREDIT_DELAY; i++) begin
                r_cr_v[i]  <= 1'b0;
                r_cr_vc[i] <= '0;
            end
        end else begin
            for (int i = CREDIT_DELAY - 1; i > 0; i--) begin
                r_cr_v[i]  <= r_cr_v[i-1];
                r_cr_vc[i] <= r_cr_vc[i-1];
            end
            r_cr_v[0]  <= w_acc;
            r_cr_vc[0] <= w_acc ? flit_vc : '0;
        end
    end

    assign cr_valid   = r_cr_v[CREDIT_DELAY-1];
    assign cr_vc      = r_cr_vc[CREDIT_DELAY-1];
    assign pkt_count  = r_pkt_count;
    assign flit_count = r_flit_count;
    assign done       = r_done;
    assign err        = r_err;
    assign err_code   = r_err_code;

endmodule

// File: tb/tb_eject_sink.sv
// Directed bench for eject_sink: framing, destination, overflow,
// credit timing and mid-packet reset.
module tb_eject_sink;

    localparam int NODE = 5;
    localparam int CD   = 3;

    logic        clk;
    logic        rst_n;
    logic [3:0]  op;
    logic [9:0]  init_count;
    logic        flit_full;
    logic [1:0]  flit_vc;
    logic        flit_head;
    logic        flit_tail;
    logic [13:0] flit_dst;
    logic        cr_valid;
    logic [1:0]  cr_vc;
    logic [9:0]  pkt_count;
    logic [9:0]  flit_count;
    logic        done;
    logic        err;
    logic [1:0]  err_code;

    int n_vec;
    int n_bad;

    eject_sink #(
        .NODE_ID(NODE), .NUM_VC(4), .VC_BITS(2), .DST_BITS(14),
        .CNT_BITS(10), .CREDIT_DELAY(CD)
    ) dut (
        .clk(clk), .rst_n(rst_n), .op(op), .init_count(init_count),
        .flit_full(flit_full), .flit_vc(flit_vc), .flit_head(flit_head),
        .flit_tail(flit_tail), .flit_dst(flit_dst),
        .cr_valid(cr_valid), .cr_vc(cr_vc), .pkt_count(pkt_count),
        .flit_count(flit_count), .done(done), .err(err), .err_code(err_code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic full, input logic [1:0] vc,
                        input logic h, input logic t, input logic [13:0] dst);
        flit_full = full;
        flit_vc   = vc;
        flit_head = h;
        flit_tail = t;
        flit_dst  = dst;
        tick();
        flit_full = 1'b0;
    endtask

    task automatic idle();
        send(1'b0, 2'd0, 1'b0, 1'b0, 14'(NODE));
    endtask

    task automatic init(input logic [9:0] cnt);
        op         = 4'd5;
        init_count = cnt;
        tick();
        op         = 4'd0;
    endtask

    logic       exp_v  [7];
    logic [1:0] exp_vc [7];

    initial begin
        n_vec = 0;
        n_bad = 0;
        rst_n = 1'b0;
        op = 4'd0;
        init_count = '0;
        flit_full = 1'b0;
        flit_vc = '0;
        flit_head = 1'b0;
        flit_tail = 1'b0;
        flit_dst = '0;
        tick();
        tick();
        chk("rst_cr_valid", cr_valid, 0);
        chk("rst_pkt", pkt_count, 0);
        chk("rst_flit", flit_count, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_code", err_code, 0);
        rst_n = 1'b1;
        tick();

        // single-flit packet then 3-flit packet
        init(10'd2);
        chk("t1_done_init", done, 0);
        send(1, 2'd0, 1, 1, 14'(NODE));
        chk("t1_pkt1", pkt_count, 1);
        send(1, 2'd1, 1, 0, 14'(NODE));
        send(1, 2'd1, 0, 0, 14'(NODE));
        chk("t1_done_mid", done, 0);
        send(1, 2'd1, 0, 1, 14'(NODE));
        chk("t1_pkt", pkt_count, 2);
        chk("t1_flit", flit_count, 4);
        chk("t1_done", done, 1);
        chk("t1_err", err, 0);

        // back-to-back credits, delay 3
        init(10'd9);
        exp_v  = '{0, 0, 1, 1, 1, 1, 0};
        exp_vc = '{0, 0, 2, 2, 3, 2, 0};
        for (int k = 0; k < 7; k++) begin
            case (k)
                0: send(1, 2'd2, 1, 0, 14'(NODE));
                1: send(1, 2'd2, 0, 0, 14'(NODE));
                2: send(1, 2'd3, 1, 1, 14'(NODE));
                3: send(1, 2'd2, 0, 1, 14'(NODE));
                default: idle();
            endcase
            chk($sformatf("t2_crv%0d", k), cr_valid, exp_v[k]);
            if (exp_v[k]) chk($sformatf("t2_crvc%0d", k), cr_vc, exp_vc[k]);
        end
        chk("t2_pkt", pkt_count, 2);

        // interleaved packets on vc0 / vc1
        init(10'd2);
        send(1, 2'd0, 1, 0, 14'(NODE));
        send(1, 2'd1, 1, 0, 14'(NODE));
        send(1, 2'd0, 0, 0, 14'(NODE));
        send(1, 2'd1, 0, 1, 14'(NODE));
        chk("t3_done_mid", done, 0);
        chk("t3_pkt_mid", pkt_count, 1);
        send(1, 2'd0, 0, 1, 14'(NODE));
        chk("t3_pkt", pkt_count, 2);
        chk("t3_err", err, 0);
        chk("t3_done", done, 1);

        // framing errors: body on idle vc, head on busy vc
        init(10'd5);
        send(1, 2'd0, 0, 0, 14'(NODE));
        chk("t4_err", err, 1);
        chk("t4_code", err_code, 1);
        send(1, 2'd1, 1, 0, 14'(NODE));
        send(1, 2'd1, 1, 0, 14'(NODE));
        chk("t4_err2", err, 1);
        chk("t4_code2", err_code, 1);
        chk("t4_cr0v", cr_valid, 1);
        chk("t4_cr0vc", cr_vc, 0);
        idle();
        chk("t4_cr1v", cr_valid, 1);
        chk("t4_cr1vc", cr_vc, 1);
        idle();
        chk("t4_cr2v", cr_valid, 1);
        chk("t4_cr2vc", cr_vc, 1);
        chk("t4_flit", flit_count, 3);

        // destination mismatch
        init(10'd5);
        chk("t5_err_clr", err, 0);
        send(1, 2'd0, 1, 1, 14'(NODE + 1));
        chk("t5_code", err_code, 2);
        chk("t5_pkt", pkt_count, 1);
        chk("t5_flit", flit_count, 1);

        // overflow
        init(10'd1);
        chk("t6_done0", done, 0);
        send(1, 2'd2, 1, 1, 14'(NODE));
        chk("t6_done1", done, 1);
        chk("t6_err0", err, 0);
        send(1, 2'd2, 1, 1, 14'(NODE));
        chk("t6_code", err_code, 3);
        chk("t6_done2", done, 0);
        chk("t6_pkt", pkt_count, 2);

        // asynchronous reset mid-packet with credits pending
        init(10'd5);
        send(1, 2'd0, 1, 0, 14'(NODE));
        send(1, 2'd1, 1, 0, 14'(NODE));
        chk("t7_flit_pre", flit_count, 2);
        rst_n = 1'b0;
        #1;
        chk("t7_flit", flit_count, 0);
        chk("t7_cr", cr_valid, 0);
        chk("t7_pkt", pkt_count, 0);
        chk("t7_done", done, 0);
        chk("t7_err", err, 0);
        #3;
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            idle();
            chk($sformatf("t7_nocr%0d", k), cr_valid, 0);
        end
        chk("t7_done_unarmed", done, 0);
        init(10'd0);
        chk("t7_done_zero", done, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/eject_sink.md
Name: eject_sink

Overview:
- Per-node ejection endpoint, directly downstream of a router's local output port; it consumes the flits the router delivers to its own node.
- Tracks per-VC packet framing (head/body/tail) and checks each flit's destination against the node ID.
- Returns credits to the router after a configurable delay and counts received flits and packets.
- Raises done once the expected packet count has arrived, so the top-level CheckEnd state can end the simulation.

Parameters:
- NODE_ID, 0, router index of this node; compared with FlitDst.
- NUM_VC, 4, number of virtual channels (maxvc).
- VC_BITS, 2, width of the VC field, clog2(NUM_VC).
- DST_BITS, 14, width of the FlitDst field (DestSize).
- CNT_BITS, 10, width of the packet/flit counters and of the expected count (TotalNumTraffic width).
- CREDIT_DELAY, 1, cycles from flit acceptance to credit pulse; legal range 1..8.

Ports:
- clk, in, 1, system clock.
- rst_n, in, 1, asynchronous active-low reset.
- op, in, 4, command: NOP=0, Init=5; all other codes are treated as NOP.
- init_count, in, CNT_BITS, expected packet count; sampled on Init.
- flit_full, in, 1, flit present this cycle (BufferFull).
- flit_vc, in, VC_BITS, VC of the incoming flit.
- flit_head, in, 1, head marker.
- flit_tail, in, 1, tail marker.
- flit_dst, in, DST_BITS, destination field.
- cr_valid, out, 1, credit pulse to the router.
- cr_vc, out, VC_BITS, VC being credited.
- pkt_count, out, CNT_BITS, completed packets.
- flit_count, out, CNT_BITS, accepted flits.
- done, out, 1, all expected packets received and no packet in flight.
- err, out, 1, sticky protocol error.
- err_code, out, 2, first error: 1 = framing, 2 = destination mismatch, 3 = overflow.

Behaviour:
- Reset (rst_n=0, asynchronous): all outputs 0; every VC in IDLE; credit pipe cleared; expected=0; armed=0.
- Init (op=5):
  - Synchronously loads expected=init_count and sets armed=1.
  - Clears counters, err, err_code, VC states and the credit pipe.
  - A flit presented in the same cycle is ignored and earns no credit.
- Acceptance: every cycle with flit_full=1 (and op!=Init) accepts exactly one flit. No back-pressure exists; credits guarantee space.
- Per-VC FSM, states IDLE and BUSY:
  - IDLE + head&tail: packet complete, pkt_count+1, stay IDLE.
  - IDLE + head&!tail: go to BUSY.
  - BUSY + !head&!tail: stay BUSY.
  - BUSY + !head&tail: pkt_count+1, go to IDLE.
  - IDLE + !head: framing error; the flit is counted and credited, state unchanged.
  - BUSY + head: framing error; the old packet is abandoned, the new one starts, and the state is BUSY or IDLE per tail.
- Destination check: flit_dst != NODE_ID sets error code 2. The flit is still counted, credited and framed.
- Overflow: pkt_count reaching expected+1 sets error code 3.
- Errors: err and err_code latch the first error only; cleared by reset or Init.
- flit_count: +1 per accepted flit. Both counters saturate at all-ones.
- Credits:
  - Each accepted flit pushes its VC into a CREDIT_DELAY-deep shift pipe.
  - cr_valid/cr_vc appear exactly CREDIT_DELAY cycles after the acceptance edge, one credit per accepted flit, in order.
  - Back-to-back flits produce back-to-back credits.
- done:
  - Registered: armed & (pkt_count==expected) & all VCs IDLE.
  - Goes high on the edge after the completing tail; drops if an overflow later occurs.
  - With expected=0, done=1 on the cycle after Init.
- Counter and FSM updates all take effect on the same posedge as acceptance; outputs are registered.
- Reset asserted mid-packet: discards all state immediately, including pending credits.

Test Plan:
- Init count=2. Send a single-flit packet (head&tail, vc0, dst=NODE_ID), then a 3-flit packet on vc1 → pkt_count=2, flit_count=4, done rises the cycle after the tail, err=0.
- CREDIT_DELAY=3. Four back-to-back flits on vc2,vc2,vc3,vc2 → cr_valid high on cycles t+3..t+6 with cr_vc=2,2,3,2.
- Interleave packets on vc0 and vc1 (H0,H1,B0,T1,T0) with count=2 → pkt_count=2, err=0, done=1.
- Body flit on an IDLE vc, then a head flit while BUSY → err=1, err_code=1 (first error held), credits still issued for both flits.
- Flit with dst=NODE_ID+1 → err_code=2. Init count=1 then 2 packets → err_code=3 and done returns to 0.
- Assert rst_n low for half a cycle mid-packet with credits pending → all outputs 0 immediately, no credit after release. Init count=0 → done=1 next cycle.
